aes_spi_stream_engine: RTL and testbench

- Multi-block, dual-mode successor to the single-block SPI encrypt/decrypt drivers.
- Sits between the byte-level SPI `slave` (`data_out`/`done`/`data_in`) and an external sequential AES core with a start/done handshake.
- Accepts a command byte and a key, then up to MAX_BLOCKS 128-bit blocks per `cs` frame.
- Runs each block through the core, encrypt or decrypt, and streams every result back over SPI behind a status preamble.

---
 rtl/aes_spi_stream_engine.sv | 210 +++++++++++++++++++++
 tb/tb_aes_spi_stream_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_stream_engine.sv
// Frame-level sequencer between a byte-wide SPI slave and a start/done AES core.
// Per cs frame: command byte, key, then up to MAX_BLOCKS blocks, each result sent behind a READY preamble.
//   state     | meaning
//   S_IDLE    | no frame; waiting for cs low
//   S_CMD     | waiting for the command byte
//   S_KEY     | collecting 16/24/32 key bytes
//   S_DATA    | collecting 16 block bytes
//   S_COMPUTE | core running; host polls and reads BUSY_BYTE
//   S_READY   | result latched; host is reading READY_BYTE
//   S_SEND    | streaming the 16 result bytes
//   S_DONE    | all blocks sent; BUSY_BYTE until cs high
//   S_ERROR   | bad command or core timeout; ERR_BYTE until cs high
module aes_spi_stream_engine #(
  parameter int         MAX_BLOCKS = 8,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] BUSY_BYTE  = 8'h00,
  parameter logic [7:0] READY_BYTE = 8'hC3,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [7:0]   tx_byte,
  output logic         core_start,
  output logic         core_mode,
  output logic [1:0]   core_key_len,
  output logic [255:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         err,
  output logic [5:0]   blocks_done
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_KEY, S_DATA, S_COMPUTE, S_READY, S_SEND, S_DONE, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     tx_q, tx_d;
  logic           start_q, start_d;
  logic           mode_q, mode_d;
  logic [1:0]     klen_q, klen_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   blk_q, blk_d;
  logic [127:0]   res_q, res_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [5:0]     n_q, n_d;
  logic [5:0]     bdone_q, bdone_d;

  logic [5:0]     n_cmd;
  logic [4:0]     key_last;
  logic [7:0]     key_lsb;
  logic [6:0]     blk_lsb;
  logic [3:0]     res_nxt;
  logic [6:0]     res_lsb;

  assign n_cmd    = {1'b0, rx_byte[7:3]} + 6'd1;
  assign key_last = 5'd15 + {klen_q, 3'b000};
  // Byte k of a left-aligned field sits at bit offset 8*(last-k); ~k gives last-k.
  assign key_lsb  = {~cnt_q, 3'b000};
  assign blk_lsb  = {~cnt_q[3:0], 3'b000};
  assign res_nxt  = cnt_q[3:0] + 4'd1;
  assign res_lsb  = {~res_nxt, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= BUSY_BYTE;
      start_q <= 1'b0;
      mode_q  <= 1'b0;
      klen_q  <= 2'b00;
      key_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      n_q     <= '0;
      bdone_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      klen_q  <= klen_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      n_q     <= n_d;
      bdone_q <= bdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    start_d = 1'b0;
    mode_d  = mode_q;
    klen_d  = klen_q;
    key_d   = key_q;
    blk_d   = blk_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    n_d     = n_q;
    bdone_d = bdone_q;

    // Deselect aborts the frame from any state; blocks_done survives until the next frame.
    if (state_q != S_IDLE && cs) begin
      state_d = S_IDLE;
      tx_d    = BUSY_BYTE;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (!cs) begin
          state_d = S_CMD;
          tx_d    = BUSY_BYTE;
          bdone_d = '0;
          cnt_d   = '0;
        end
        S_CMD: if (rx_valid) begin
          if (rx_byte[2:1] == 2'b11 || n_cmd > 6'(MAX_BLOCKS)) begin
            state_d = S_ERROR;
            tx_d    = ERR_BYTE;
          end else begin
            state_d = S_KEY;
            mode_d  = rx_byte[0];
            klen_d  = rx_byte[2:1];
            n_d     = n_cmd;
            key_d   = '0;
            cnt_d   = '0;
          end
        end
        S_KEY: if (rx_valid) begin
          key_d[key_lsb +: 8] = rx_byte;
          if (cnt_q == key_last) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DATA: if (rx_valid) begin
          blk_d[blk_lsb +: 8] = rx_byte;
          if (cnt_q[3:0] == 4'd15) begin
            state_d = S_COMPUTE;
            tx_d    = BUSY_BYTE;
            start_d = 1'b1;
            cnt_d   = '0;
            tmr_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_COMPUTE: begin
          // Host polls are ignored here; a poll colliding with core_done still read BUSY.
          if (core_done) begin
            state_d = S_READY;
            res_d   = core_result;
            tx_d    = READY_BYTE;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
            tx_d    = ERR_BYTE;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_READY: if (rx_valid) begin
          state_d = S_SEND;
          tx_d    = res_q[127:120];
          cnt_d   = '0;
        end
        S_SEND: if (rx_valid) begin
          if (cnt_q[3:0] == 4'd15) begin
            bdone_d = bdone_q + 6'd1;
            tx_d    = BUSY_BYTE;
            cnt_d   = '0;
            state_d = ((bdone_q + 6'd1) < n_q) ? S_DATA : S_DONE;
          end else begin
            tx_d  = res_q[res_lsb +: 8];
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DONE:  ;
        S_ERROR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tx_byte      = tx_q;
  assign core_start   = start_q;
  assign core_mode    = mode_q;
  assign core_key_len = klen_q;
  assign core_key     = key_q;
  assign core_block   = blk_q;
  assign busy         = (state_q != S_IDLE);
  assign err          = (state_q == S_ERROR);
  assign blocks_done  = bdone_q;

endmodule

// File: tb/tb_aes_spi_stream_engine.sv
// Self-checking bench: a host/core protocol model predicts every output each cycle,
// plus literal FIPS-197 and boundary expectations.
module tb_aes_spi_stream_engine;

  localparam int MAXB = 8;
  localparam int TMO  = 1024;

  logic         clk = 1'b0;
  logic         reset, cs, rx_valid, core_done;
  logic [7:0]   rx_byte, tx_byte;
  logic         core_start, core_mode, busy, err;
  logic [1:0]   core_key_len;
  logic [255:0] core_key;
  logic [127:0] core_block, core_result;
  logic [5:0]   blocks_done;

  always #5 clk = ~clk;

  aes_spi_stream_engine dut (
    .clk(clk), .reset(reset), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .core_start(core_start), .core_mode(core_mode),
    .core_key_len(core_key_len), .core_key(core_key), .core_block(core_block),
    .core_done(core_done), .core_result(core_result), .busy(busy), .err(err),
    .blocks_done(blocks_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // model of the visible outputs
  logic [7:0]   m_tx;
  logic         m_busy, m_err, m_start, m_mode;
  logic [1:0]   m_klen;
  logic [5:0]   m_bd;
  bit           chk_en = 0;

  // core model and frame data
  bit           core_wait, res_ready, nogap;
  int           core_cnt, waited, last_polls;
  logic [127:0] cur_res;
  logic [127:0] f_pt [32];
  logic [127:0] f_res [32];
  int           f_lat [32];

  // independent monitors
  int cyc = 0, n_starts = 0, st_cyc = 0, err_cyc = 0;
  bit err_prev = 0;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_byte", tx_byte, m_tx);
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      chk("core_start", core_start, m_start);
      chk("blocks_done", blocks_done, m_bd);
      chk("core_mode", core_mode, m_mode);
      chk("core_key_len", core_key_len, m_klen);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (core_start === 1'b1) begin
      n_starts++;
      st_cyc = cyc;
    end
    if (err === 1'b1 && !err_prev) err_cyc = cyc;
    err_prev = (err === 1'b1);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step(input logic rv, input logic [7:0] rb);
    logic d;
    rx_valid    = rv;
    rx_byte     = rb;
    core_done   = 1'b0;
    core_result = rand128();
    if (core_wait && core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done   = 1'b1;
        core_result = cur_res;
      end
    end else if (!core_wait && $urandom_range(15) == 0) begin
      core_done = 1'b1;
    end
    d = core_done;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    core_done = 1'b0;
    m_start   = 1'b0;
    if (core_wait) begin
      if (d) begin
        core_wait = 0;
        res_ready = 1;
        m_tx      = 8'hC3;
      end else begin
        waited++;
        if (waited == TMO) begin
          core_wait = 0;
          m_err     = 1'b1;
          m_tx      = 8'hEE;
        end
      end
    end
  endtask

  task automatic gap();
    if (!nogap) repeat ($urandom_range(2)) step(1'b0, 8'h00);
  endtask

  task automatic xchg(input logic [7:0] b, input logic [7:0] exp, input string nm);
    logic [7:0] got;
    got = tx_byte;
    step(1'b1, b);
    chk(nm, got, exp);
  endtask

  task automatic end_frame();
    cs        = 1'b1;
    core_wait = 0;
    step(1'b0, 8'h00);
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_tx   = 8'h00;
    step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    core_wait = 0;
    step(1'b0, 8'h00);
    reset  = 1'b0;
    m_tx   = 8'h00;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_bd   = '0;
    m_mode = 1'b0;
    m_klen = 2'b00;
    chk("rst_core_key", core_key, 256'h0);
    chk("rst_core_block", core_block, 128'h0);
    cs = 1'b1;
    step(1'b0, 8'h00);
  endtask

  task automatic fill(input int n, input int lmin, input int lmax);
    for (int b = 0; b < n; b++) begin
      f_pt[b]  = rand128();
      f_res[b] = rand128();
      f_lat[b] = $urandom_range(lmax, lmin);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [255:0] key,
                           input int abort_key, input int abort_send);
    int           kc, n, kbytes, guard, polls;
    logic [255:0] kexp;
    logic [7:0]   exp;
    bit           was;
    cs = 1'b0;
    step(1'b0, 8'h00);
    m_busy = 1'b1;
    m_bd   = '0;
    m_tx   = 8'h00;
    kc = int'(cmd[2:1]);
    n  = int'(cmd[7:3]) + 1;
    gap();
    xchg(cmd, 8'h00, "cmd_read");
    if (kc == 3 || n > MAXB) begin
      m_err = 1'b1;
      m_tx  = 8'hEE;
      for (int i = 0; i < 3; i++) begin
        gap();
        xchg(8'($urandom()), 8'hEE, "err_read");
      end
      chk("err_flag_lit", err, 1'b1);
      chk("err_tx_lit", tx_byte, 8'hEE);
      end_frame();
      return;
    end
    m_mode = cmd[0];
    m_klen = cmd[2:1];
    kbytes = 16 + 8 * kc;
    kexp   = key & ({256{1'b1}} << (256 - 8 * kbytes));
    for (int i = 0; i < kbytes; i++) begin
      if (i == abort_key) begin
        end_frame();
        return;
      end
      gap();
      xchg(kexp[255 - 8 * i -: 8], 8'h00, "key_read");
    end
    chk("core_key", core_key, kexp);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 16; i++) begin
        gap();
        xchg(f_pt[b][127 - 8 * i -: 8], 8'h00, "data_read");
      end
      m_start   = 1'b1;
      core_wait = 1;
      core_cnt  = f_lat[b];
      waited    = 0;
      cur_res   = f_res[b];
      res_ready = 0;
      chk("core_block", core_block, f_pt[b]);
      chk("key_hold", core_key, kexp);
      polls = 0;
      guard = 0;
      was   = 0;
      while (!was && !m_err && guard < 3000) begin
        gap();
        was = res_ready && !m_err;
        exp = m_err ? 8'hEE : (res_ready ? 8'hC3 : 8'h00);
        xchg(8'($urandom()), exp, "poll_read");
        if (!was) polls++;
        guard++;
      end
      last_polls = polls;
      if (m_err) begin
        end_frame();
        return;
      end
      if (!was) begin
        chk("poll_budget", was, 1'b1);
        end_frame();
        return;
      end
      m_tx = f_res[b][127:120];
      for (int i = 0; i < 16; i++) begin
        if (b == 0 && i == abort_send) begin
          do_reset();
          return;
        end
        gap();
        xchg(8'($urandom()), f_res[b][127 - 8 * i -: 8], "result_read");
        if (i < 15) m_tx = f_res[b][119 - 8 * i -: 8];
        else begin
          m_bd = m_bd + 6'd1;
          m_tx = 8'h00;
        end
      end
    end
    repeat (2) step(1'b0, 8'h00);
    end_frame();
  endtask

  initial begin
    int s0, n, kc;
    logic [4:0] nf;
    reset = 1'b1; cs = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    core_done = 1'b0; core_result = '0;
    m_tx = 8'h00; m_busy = 1'b0; m_err = 1'b0; m_start = 1'b0;
    m_mode = 1'b0; m_klen = 2'b00; m_bd = '0;
    core_wait = 0; res_ready = 0; nogap = 0; core_cnt = 0; waited = 0; last_polls = 0;
    step(1'b0, 8'h00);
    chk_en = 1;
    step(1'b0, 8'h00);
    reset = 1'b0;
    step(1'b0, 8'h00);
    chk("rst_tx_lit", tx_byte, 8'h00);
    chk("rst_key_lit", core_key, 256'h0);
    chk("rst_block_lit", core_block, 128'h0);

    // FIPS-197 single block, encrypt, 128-bit key
    f_pt[0]  = 128'h00112233445566778899aabbccddeeff;
    f_res[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    f_lat[0] = 20;
    s0 = n_starts;
    run_frame(8'h00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, -1, -1);
    chk("fips_key_lit", core_key[255:128], 128'h000102030405060708090a0b0c0d0e0f);
    chk("fips_bd_lit", blocks_done, 6'd1);
    chk("fips_starts", n_starts - s0, 1);

    // decrypt, 256-bit key, three blocks
    fill(3, 1, 40);
    s0 = n_starts;
    run_frame(8'h15, {rand128(), rand128()}, -1, -1);
    chk("dec_mode_lit", core_mode, 1'b1);
    chk("dec_klen_lit", core_key_len, 2'b10);
    chk("dec_bd_lit", blocks_done, 6'd3);
    chk("dec_starts", n_starts - s0, 3);

    // illegal commands: key code 11, then N = MAX_BLOCKS+1
    s0 = n_starts;
    run_frame(8'h06, {rand128(), rand128()}, -1, -1);
    run_frame(8'h40, {rand128(), rand128()}, -1, -1);
    chk("illegal_starts", n_starts - s0, 0);
    chk("illegal_err_clr", err, 1'b0);

    // core timeout
    f_pt[0] = rand128(); f_res[0] = rand128(); f_lat[0] = 0;
    run_frame(8'h00, {rand128(), rand128()}, -1, -1);
    chk("timeout_latency", err_cyc - st_cyc, TMO);

    // abort after 10 key bytes, then a normal two-block frame
    run_frame(8'h02, {rand128(), rand128()}, 10, -1);
    chk("abort_busy_lit", busy, 1'b0);
    fill(2, 1, 30);
    run_frame(8'h0A, {rand128(), rand128()}, -1, -1);
    chk("after_abort_bd_lit", blocks_done, 6'd2);

    // core_done coincident with the third poll
    nogap = 1;
    f_pt[0] = rand128(); f_res[0] = rand128(); f_lat[0] = 3;
    run_frame(8'h00, {rand128(), rand128()}, -1, -1);
    chk("collision_polls_lit", last_polls, 3);
    nogap = 0;

    // synchronous reset in the middle of SEND
    fill(2, 1, 20);
    run_frame(8'h08, {rand128(), rand128()}, -1, 5);
    chk("rst_send_bd_lit", blocks_done, 6'd0);

    // MAX_BLOCKS boundary, then random legal frames
    fill(MAXB, 1, 10);
    run_frame({5'(MAXB - 1), 2'b01, 1'b1}, {rand128(), rand128()}, -1, -1);
    chk("maxb_bd", blocks_done, 6'(MAXB));
    for (int t = 0; t < 5; t++) begin
      n  = $urandom_range(4, 1);
      kc = $urandom_range(2);
      nf = 5'(n - 1);
      fill(n, 1, 50);
      run_frame({nf, 2'(kc), 1'($urandom_range(1))}, {rand128(), rand128()}, -1, -1);
      chk("rand_bd", blocks_done, 6'(n));
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
